// File: rtl/tl_ul_arb_2to1.sv
// tl_ul_arb_2to1: two-master to one-slave TileLink-UL (32-bit, single-beat) arbiter.
//
// A channel: round-robin between the two masters with a sticky grant so that a
// stalled request keeps s_a_* stable until it is accepted. The granted master's
// index is prepended to its source ID on s_a_source.
// D channel: responses are routed back by s_d_source[SRC_W]; fields fan out to
// both masters with only the low SRC_W source bits.
// Each master has a 4-bit outstanding counter; a master at MAX_OUT is not
// eligible for the A channel until a response returns.
//
// Optional build macro: TL_ARB_FIXED_PRIO_EN -- replaces round-robin with a
// fixed priority where master 0 wins whenever both masters are eligible.
//
// Ports:
//   clock, reset_n                 clock and asynchronous active-low reset
//   m0_a_* / m1_a_*                upstream A channels (valid/ready + fields)
//   m0_d_* / m1_d_*                upstream D channels (valid/ready + fields)
//   s_a_*                          downstream A channel, source = {idx, src}
//   s_d_*                          downstream D channel
//   m0_outstanding/m1_outstanding  per-master outstanding count (debug)
module tl_ul_arb_2to1 #(
    parameter int unsigned ADDR_W  = 30,
    parameter int unsigned SRC_W   = 2,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                m0_a_valid,
    output logic                m0_a_ready,
    input  logic [2:0]          m0_a_opcode,
    input  logic [2:0]          m0_a_param,
    input  logic [1:0]          m0_a_size,
    input  logic [SRC_W-1:0]    m0_a_source,
    input  logic [ADDR_W-1:0]   m0_a_address,
    input  logic [3:0]          m0_a_mask,
    input  logic [31:0]         m0_a_data,
    output logic                m0_d_valid,
    input  logic                m0_d_ready,
    output logic [2:0]          m0_d_opcode,
    output logic [1:0]          m0_d_param,
    output logic [1:0]          m0_d_size,
    output logic [SRC_W-1:0]    m0_d_source,
    output logic                m0_d_denied,
    output logic                m0_d_corrupt,
    output logic [31:0]         m0_d_data,

    input  logic                m1_a_valid,
    output logic                m1_a_ready,
    input  logic [2:0]          m1_a_opcode,
    input  logic [2:0]          m1_a_param,
    input  logic [1:0]          m1_a_size,
    input  logic [SRC_W-1:0]    m1_a_source,
    input  logic [ADDR_W-1:0]   m1_a_address,
    input  logic [3:0]          m1_a_mask,
    input  logic [31:0]         m1_a_data,
    output logic                m1_d_valid,
    input  logic                m1_d_ready,
    output logic [2:0]          m1_d_opcode,
    output logic [1:0]          m1_d_param,
    output logic [1:0]          m1_d_size,
    output logic [SRC_W-1:0]    m1_d_source,
    output logic                m1_d_denied,
    output logic                m1_d_corrupt,
    output logic [31:0]         m1_d_data,

    output logic                s_a_valid,
    input  logic                s_a_ready,
    output logic [2:0]          s_a_opcode,
    output logic [2:0]          s_a_param,
    output logic [1:0]          s_a_size,
    output logic [SRC_W:0]      s_a_source,
    output logic [ADDR_W-1:0]   s_a_address,
    output logic [3:0]          s_a_mask,
    output logic [31:0]         s_a_data,

    input  logic                s_d_valid,
    output logic                s_d_ready,
    input  logic [2:0]          s_d_opcode,
    input  logic [1:0]          s_d_param,
    input  logic [1:0]          s_d_size,
    input  logic [SRC_W:0]      s_d_source,
    input  logic                s_d_denied,
    input  logic                s_d_corrupt,
    input  logic [31:0]         s_d_data,

    output logic [3:0]          m0_outstanding,
    output logic [3:0]          m1_outstanding
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic             lock_q, lock_d;
    logic             lock_idx_q, lock_idx_d;
    logic [CNT_W-1:0] out0_q, out0_d;
    logic [CNT_W-1:0] out1_q, out1_d;
`ifndef TL_ARB_FIXED_PRIO_EN
    logic             rr_ptr_q, rr_ptr_d;
`endif

    logic elig0, elig1;
    logic sel;
    logic a_valid_raw;
    logic a_fire;
    logic d_idx;
    logic d_fire;
    logic inc0, inc1, dec0, dec1;

    assign elig0 = m0_a_valid & (out0_q != CNT_MAX);
    assign elig1 = m1_a_valid & (out1_q != CNT_MAX);

    // Grant selection: locked master first, otherwise the lone or preferred eligible one
    always_comb begin
        sel = 1'b0;
        if (lock_q) begin
            sel = lock_idx_q;
        end else if (elig0 && elig1) begin
`ifdef TL_ARB_FIXED_PRIO_EN
            sel = 1'b0;
`else
            sel = rr_ptr_q;
`endif
        end else if (elig1) begin
            sel = 1'b1;
        end
    end

    // A-channel mux; handshakes are forced low while reset is held
    assign a_valid_raw = sel ? elig1 : elig0;
    assign s_a_valid   = reset_n & a_valid_raw;
    assign a_fire      = s_a_valid & s_a_ready;
    assign m0_a_ready  = reset_n & s_a_ready & ~sel & elig0;
    assign m1_a_ready  = reset_n & s_a_ready &  sel & elig1;

    assign s_a_opcode  = sel ? m1_a_opcode  : m0_a_opcode;
    assign s_a_param   = sel ? m1_a_param   : m0_a_param;
    assign s_a_size    = sel ? m1_a_size    : m0_a_size;
    assign s_a_source  = {sel, (sel ? m1_a_source : m0_a_source)};
    assign s_a_address = sel ? m1_a_address : m0_a_address;
    assign s_a_mask    = sel ? m1_a_mask    : m0_a_mask;
    assign s_a_data    = sel ? m1_a_data    : m0_a_data;

    // D-channel routing by the source tag bit
    assign d_idx      = s_d_source[SRC_W];
    assign m0_d_valid = reset_n & s_d_valid & ~d_idx;
    assign m1_d_valid = reset_n & s_d_valid &  d_idx;
    assign s_d_ready  = reset_n & (d_idx ? m1_d_ready : m0_d_ready);
    assign d_fire     = s_d_valid & s_d_ready;

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_param   = s_d_param;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[SRC_W-1:0];
    assign m0_d_denied  = s_d_denied;
    assign m0_d_corrupt = s_d_corrupt;
    assign m0_d_data    = s_d_data;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_param   = s_d_param;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[SRC_W-1:0];
    assign m1_d_denied  = s_d_denied;
    assign m1_d_corrupt = s_d_corrupt;
    assign m1_d_data    = s_d_data;

    assign inc0 = a_fire & ~sel;
    assign inc1 = a_fire &  sel;
    assign dec0 = d_fire & ~d_idx;
    assign dec1 = d_fire &  d_idx;

    // Next-state: sticky grant, round-robin pointer, outstanding counters
    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        out0_d     = out0_q;
        out1_d     = out1_q;
`ifndef TL_ARB_FIXED_PRIO_EN
        rr_ptr_d   = rr_ptr_q;
`endif
        if (a_fire) begin
            lock_d   = 1'b0;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr_d = ~sel;
`endif
        end else if (a_valid_raw && !s_a_ready) begin
            lock_d     = 1'b1;
            lock_idx_d = sel;
        end

        // Increment only happens when eligible, so the counter cannot pass MAX_OUT;
        // a stray response at zero saturates rather than wrapping.
        if (inc0 && !dec0) begin
            out0_d = out0_q + CNT_W'(1);
        end else if (dec0 && !inc0 && (out0_q != '0)) begin
            out0_d = out0_q - CNT_W'(1);
        end
        if (inc1 && !dec1) begin
            out1_d = out1_q + CNT_W'(1);
        end else if (dec1 && !inc1 && (out1_q != '0)) begin
            out1_d = out1_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lock_q     <= 1'b0;
            lock_idx_q <= 1'b0;
            out0_q     <= '0;
            out1_q     <= '0;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= 1'b0;
`endif
        end else begin
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            out0_q     <= out0_d;
            out1_q     <= out1_d;
`ifndef TL_ARB_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    assign m0_outstanding = out0_q;
    assign m1_outstanding = out1_q;

endmodule

// File: tb/tb_tl_ul_arb_2to1.sv
// Directed testbench for tl_ul_arb_2to1 (default parameters).
module tb_tl_ul_arb_2to1;

    localparam int unsigned ADDR_W = 30;
    localparam int unsigned SRC_W  = 2;

    logic clock, reset_n;

    logic              m0_a_valid, m0_a_ready, m1_a_valid, m1_a_ready;
    logic [2:0]        m0_a_opcode, m0_a_param, m1_a_opcode, m1_a_param;
    logic [1:0]        m0_a_size, m1_a_size;
    logic [SRC_W-1:0]  m0_a_source, m1_a_source;
    logic [ADDR_W-1:0] m0_a_address, m1_a_address;
    logic [3:0]        m0_a_mask, m1_a_mask;
    logic [31:0]       m0_a_data, m1_a_data;

    logic              m0_d_valid, m0_d_ready, m1_d_valid, m1_d_ready;
    logic [2:0]        m0_d_opcode, m1_d_opcode;
    logic [1:0]        m0_d_param, m0_d_size, m1_d_param, m1_d_size;
    logic [SRC_W-1:0]  m0_d_source, m1_d_source;
    logic              m0_d_denied, m0_d_corrupt, m1_d_denied, m1_d_corrupt;
    logic [31:0]       m0_d_data, m1_d_data;

    logic              s_a_valid, s_a_ready;
    logic [2:0]        s_a_opcode, s_a_param;
    logic [1:0]        s_a_size;
    logic [SRC_W:0]    s_a_source;
    logic [ADDR_W-1:0] s_a_address;
    logic [3:0]        s_a_mask;
    logic [31:0]       s_a_data;

    logic              s_d_valid, s_d_ready;
    logic [2:0]        s_d_opcode;
    logic [1:0]        s_d_param, s_d_size;
    logic [SRC_W:0]    s_d_source;
    logic              s_d_denied, s_d_corrupt;
    logic [31:0]       s_d_data;

    logic [3:0]        m0_outstanding, m1_outstanding;

    int checks   = 0;
    int failures = 0;

    tl_ul_arb_2to1 dut (
        .clock(clock), .reset_n(reset_n),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
        .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt), .m0_d_data(m0_d_data),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
        .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt), .m1_d_data(m1_d_data),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
        .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt), .s_d_data(s_d_data),
        .m0_outstanding(m0_outstanding), .m1_outstanding(m1_outstanding)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1ns after the rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset_n      = 1'b0;
        m0_a_valid   = 1'b1;  m1_a_valid   = 1'b0;
        m0_a_opcode  = 3'd4;  m1_a_opcode  = 3'd0;
        m0_a_param   = 3'd0;  m1_a_param   = 3'd0;
        m0_a_size    = 2'd2;  m1_a_size    = 2'd2;
        m0_a_source  = 2'b10; m1_a_source  = 2'b11;
        m0_a_address = 30'h1234_5670;
        m1_a_address = 30'h0ABC_0000;
        m0_a_mask    = 4'hF;  m1_a_mask    = 4'h3;
        m0_a_data    = 32'hDEAD_BEEF;
        m1_a_data    = 32'h0000_1111;
        m0_d_ready   = 1'b1;  m1_d_ready   = 1'b1;
        s_a_ready    = 1'b1;
        s_d_valid    = 1'b0;  s_d_opcode   = 3'd1;
        s_d_param    = 2'd0;  s_d_size     = 2'd2;
        s_d_source   = 3'b000;
        s_d_denied   = 1'b0;  s_d_corrupt  = 1'b0;
        s_d_data     = 32'h0;

        // Handshakes held low while reset is asserted
        #2;
        check("rst_s_a_valid", 64'(s_a_valid), 64'd0);
        check("rst_m0_a_ready", 64'(m0_a_ready), 64'd0);
        #10;
        reset_n    = 1'b1;
        m0_a_valid = 1'b0;
        settle();
        check("idle_s_a_valid", 64'(s_a_valid), 64'd0);
        check("idle_m0_a_ready", 64'(m0_a_ready), 64'd0);
        check("idle_m1_a_ready", 64'(m1_a_ready), 64'd0);
        check("idle_out0", 64'(m0_outstanding), 64'd0);
        check("idle_out1", 64'(m1_outstanding), 64'd0);
        tick();

`ifdef TL_ARB_FIXED_PRIO_EN
        // Master 0 wins every cycle until it hits the outstanding limit
        m0_a_valid = 1'b1; m1_a_valid = 1'b1; s_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("fp_m0_ready", 64'(m0_a_ready), 64'd1);
            check("fp_m1_ready", 64'(m1_a_ready), 64'd0);
            tick();
        end
        settle();
        check("fp_out0_full", 64'(m0_outstanding), 64'd4);
        check("fp_m0_blocked", 64'(m0_a_ready), 64'd0);
        check("fp_m1_granted", 64'(m1_a_ready), 64'd1);
        check("fp_src", 64'(s_a_source), 64'b111);
        tick();
`else
        // Contention: grants alternate 0,1,0,1
        m0_a_valid = 1'b1; m1_a_valid = 1'b1; s_a_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("rr_src", 64'(s_a_source), (i % 2 == 0) ? 64'b010 : 64'b111);
            check("rr_m0_ready", 64'(m0_a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            check("rr_m1_ready", 64'(m1_a_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
        end
        check("rr_out0", 64'(m0_outstanding), 64'd2);
        check("rr_out1", 64'(m1_outstanding), 64'd2);

        // Simultaneous A fire and D fire on master 0: counter unchanged
        m1_a_valid = 1'b0;
        s_d_valid  = 1'b1; s_d_source = 3'b001; m0_d_ready = 1'b1;
        settle();
        check("sim_m0_a_ready", 64'(m0_a_ready), 64'd1);
        check("sim_m0_d_valid", 64'(m0_d_valid), 64'd1);
        check("sim_m1_d_valid", 64'(m1_d_valid), 64'd0);
        check("sim_m0_d_source", 64'(m0_d_source), 64'b01);
        check("sim_s_d_ready", 64'(s_d_ready), 64'd1);
        tick();
        check("sim_out0", 64'(m0_outstanding), 64'd2);

        // D to master 0 with its ready low stalls the slave
        m0_a_valid = 1'b0; m0_d_ready = 1'b0; m1_d_ready = 1'b1;
        settle();
        check("dstall_s_d_ready", 64'(s_d_ready), 64'd0);
        tick();
        check("dstall_out0", 64'(m0_outstanding), 64'd2);

        // Drain master 0, then one stray response saturates at zero
        m0_d_ready = 1'b1;
        tick();
        tick();
        check("drain_out0", 64'(m0_outstanding), 64'd0);
        tick();
        check("sat_out0", 64'(m0_outstanding), 64'd0);
        s_d_source = 3'b100;
        tick();
        tick();
        check("drain_out1", 64'(m1_outstanding), 64'd0);
        s_d_valid = 1'b0;

        // Sticky stall: rr_ptr now points at master 1, but master 0's stalled
        // request keeps the grant after master 1 joins
        m0_a_valid = 1'b1; s_a_ready = 1'b0;
        settle();
        check("stk_valid", 64'(s_a_valid), 64'd1);
        check("stk_addr0", 64'(s_a_address), 64'h1234_5670);
        check("stk_m0_ready", 64'(m0_a_ready), 64'd0);
        tick();
        m1_a_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("stk_addr", 64'(s_a_address), 64'h1234_5670);
            check("stk_data", 64'(s_a_data), 64'hDEAD_BEEF);
            check("stk_src", 64'(s_a_source), 64'b010);
            check("stk_m1_ready", 64'(m1_a_ready), 64'd0);
            tick();
        end
        s_a_ready = 1'b1;
        settle();
        check("stk_fire_m0", 64'(m0_a_ready), 64'd1);
        check("stk_fire_addr", 64'(s_a_address), 64'h1234_5670);
        check("stk_fire_m1", 64'(m1_a_ready), 64'd0);
        tick();
        settle();
        check("stk_next_m1", 64'(m1_a_ready), 64'd1);
        check("stk_next_addr", 64'(s_a_address), 64'h0ABC_0000);
        check("stk_next_src", 64'(s_a_source), 64'b111);
        tick();
        check("stk_out0", 64'(m0_outstanding), 64'd1);
        check("stk_out1", 64'(m1_outstanding), 64'd1);

        // Outstanding limit on master 1
        m0_a_valid = 1'b0;
        tick();
        tick();
        tick();
        check("lim_out1", 64'(m1_outstanding), 64'd4);
        settle();
        check("lim_s_a_valid", 64'(s_a_valid), 64'd0);
        check("lim_m1_ready", 64'(m1_a_ready), 64'd0);
        m0_a_valid = 1'b1;
        settle();
        check("lim_m0_proceeds", 64'(m0_a_ready), 64'd1);
        check("lim_m0_src", 64'(s_a_source), 64'b010);
        tick();
        check("lim_out0", 64'(m0_outstanding), 64'd2);
        m0_a_valid = 1'b0;
        s_d_valid = 1'b1; s_d_source = 3'b101; s_d_data = 32'hCAFE_0001; s_d_denied = 1'b1;
        settle();
        check("lim_m1_d_valid", 64'(m1_d_valid), 64'd1);
        check("lim_m0_d_valid", 64'(m0_d_valid), 64'd0);
        check("lim_m1_d_source", 64'(m1_d_source), 64'b01);
        check("lim_m1_d_data", 64'(m1_d_data), 64'hCAFE_0001);
        check("lim_m1_d_denied", 64'(m1_d_denied), 64'd1);
        check("lim_m1_still_blk", 64'(m1_a_ready), 64'd0);
        tick();
        check("lim_out1_dec", 64'(m1_outstanding), 64'd3);
        s_d_valid = 1'b0; s_d_denied = 1'b0;
        settle();
        check("lim_m1_accept", 64'(m1_a_ready), 64'd1);
        tick();
        check("lim_out1_refill", 64'(m1_outstanding), 64'd4);
`endif

        // Reset mid-traffic clears all state immediately
        m0_a_valid = 1'b1;
        reset_n = 1'b0;
        settle();
        check("mid_rst_out0", 64'(m0_outstanding), 64'd0);
        check("mid_rst_out1", 64'(m1_outstanding), 64'd0);
        check("mid_rst_valid", 64'(s_a_valid), 64'd0);
        #2;
        reset_n = 1'b1;
        m0_a_valid = 1'b0; m1_a_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
